// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder with stall, done pulse and counters
module dmem_responder #(
  parameter int NMEM    = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [6:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
);

  localparam int AW = (NMEM > 1) ? $clog2(NMEM) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        op_wr_q;
  logic [6:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        done_q;
  logic        err_q;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] mem_q [0:NMEM-1];

  logic          req;
  logic          commit;
  logic          addr_ok;
  logic [AW-1:0] idx;

  assign req     = rd | wr;
  assign commit  = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign addr_ok = int'(addr_q) < NMEM;
  assign idx     = addr_q[AW-1:0];

  // Combinational so the CPU stalls in the very cycle a request appears.
  assign busy = ((state_q == S_IDLE) && req) || (state_q == S_WAIT);

  always_comb begin
    rd_cnt_d = (rd_cnt_q == 16'hFFFF) ? rd_cnt_q : rd_cnt_q + 16'd1;
    wr_cnt_d = (wr_cnt_q == 16'hFFFF) ? wr_cnt_q : wr_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      rdata_q  <= 32'h0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_cnt_q <= 16'h0;
      wr_cnt_q <= 16'h0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            op_wr_q <= wr;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt_q   <= 4'(LATENCY);
            state_q <= S_WAIT;
            // Write wins a rd/wr collision; the dropped read is flagged.
            if ((rd && wr) || (int'(addr) >= NMEM)) err_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            if (op_wr_q) begin
              wr_cnt_q <= wr_cnt_d;
            end else begin
              rd_cnt_q <= rd_cnt_d;
              rdata_q  <= addr_ok ? mem_q[idx] : 32'h0;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Array has no reset; an abort before the commit edge leaves it untouched.
  always_ff @(posedge clk) begin
    if (!reset && commit && op_wr_q && addr_ok) mem_q[idx] <= wdata_q;
  end

  assign rdata  = rdata_q;
  assign done   = done_q;
  assign err    = err_q;
  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;

endmodule
